// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared pipeline constants and hazard state encoding
package cpu_pipe_pkg;

    localparam int REG_AW_DEF        = 5;
    localparam int MULDIV_CYCLES_DEF = 32;

    typedef enum logic [0:0] {
        HZ_RUN       = 1'b0,
        HZ_LOAD_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hz_sat_counter.sv
// rtl/hz_sat_counter.sv - generic enabled saturating up-counter
module hz_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use / mult-div hazard detection and flush control
module hazard_ctrl_unit
    import cpu_pipe_pkg::*;
#(
    parameter int REG_AW            = REG_AW_DEF,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MULDIV_CYCLES     = MULDIV_CYCLES_DEF,
    parameter int PERF_W            = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_uses_hilo,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] exe_rt,
    input  logic              exe_mem_read,
    input  logic              exe_branch_taken,
    input  logic              exe_muldiv_start,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              muldiv_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int                MCNT_W    = $clog2(MULDIV_CYCLES + 1);
    localparam logic [1:0]        LCNT_INIT = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MULDIV_CYCLES);

    hz_state_e         state, state_nxt;
    logic [1:0]        lcnt, lcnt_nxt;
    logic [MCNT_W-1:0] mcnt;
    logic              load_hit;
    logic              hilo_hit;
    logic              stall;

    // $0 is hardwired zero, so a load targeting it is never a real producer
    assign load_hit = exe_mem_read && (exe_rt != '0) &&
                      ((id_uses_rs && (id_rs == exe_rt)) ||
                       (id_uses_rt && (id_rt == exe_rt)));

    assign muldiv_busy = (mcnt != '0);
    assign hilo_hit    = muldiv_busy && id_uses_hilo;
    assign stall       = ((state == HZ_RUN) && load_hit) ||
                         (state == HZ_LOAD_WAIT) || hilo_hit;

    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        if (exe_branch_taken) begin
            state_nxt = HZ_RUN;
            lcnt_nxt  = 2'd0;
        end else if (state == HZ_RUN) begin
            if (load_hit && (LOAD_STALL_CYCLES > 1)) begin
                state_nxt = HZ_LOAD_WAIT;
                lcnt_nxt  = LCNT_INIT;
            end
        end else begin
            if (lcnt <= 2'd1) begin
                state_nxt = HZ_RUN;
                lcnt_nxt  = 2'd0;
            end else begin
                lcnt_nxt = lcnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HZ_RUN;
            lcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
        end
    end

    // The mult/div countdown ignores pipeline stalls: the unit keeps computing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt <= '0;
        end else if (exe_muldiv_start) begin
            mcnt <= MCNT_LOAD;
        end else if (mcnt != '0) begin
            mcnt <= mcnt - MCNT_W'(1);
        end
    end

    // A stalled jump is re-presented next cycle, so its flush waits until then
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (rst) begin
            pc_write = 1'b1;
        end else if (exe_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    hz_sat_counter #(
        .W(PERF_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (~pc_write),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed bench for hazard_ctrl_unit (two configurations)
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, exe_rt = '0;
    logic       id_uses_rs = 0, id_uses_rt = 0, id_uses_hilo = 0, id_jump = 0;
    logic       exe_mem_read = 0, exe_branch_taken = 0, exe_muldiv_start = 0;

    logic        a_pc_write, a_ifid_write, a_idex_bubble, a_ifid_flush, a_muldiv_busy;
    logic [31:0] a_stall_cycles;
    logic        b_pc_write, b_ifid_write, b_idex_bubble, b_ifid_flush, b_muldiv_busy;
    logic [3:0]  b_stall_cycles;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_AW(5), .LOAD_STALL_CYCLES(1), .MULDIV_CYCLES(4), .PERF_W(32)
    ) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
        .id_jump(id_jump), .exe_rt(exe_rt), .exe_mem_read(exe_mem_read),
        .exe_branch_taken(exe_branch_taken), .exe_muldiv_start(exe_muldiv_start),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .idex_bubble(a_idex_bubble),
        .ifid_flush(a_ifid_flush), .muldiv_busy(a_muldiv_busy), .stall_cycles(a_stall_cycles)
    );

    hazard_ctrl_unit #(
        .REG_AW(5), .LOAD_STALL_CYCLES(3), .MULDIV_CYCLES(4), .PERF_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
        .id_jump(id_jump), .exe_rt(exe_rt), .exe_mem_read(exe_mem_read),
        .exe_branch_taken(exe_branch_taken), .exe_muldiv_start(exe_muldiv_start),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .idex_bubble(b_idex_bubble),
        .ifid_flush(b_ifid_flush), .muldiv_busy(b_muldiv_busy), .stall_cycles(b_stall_cycles)
    );

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; exe_rt = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0; id_jump = 0;
        exe_mem_read = 0; exe_branch_taken = 0; exe_muldiv_start = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_load_hit_rs5();
        exe_mem_read = 1; exe_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        set_load_hit_rs5();
        id_uses_hilo = 1;
        @(negedge clk); #1;
        n_total++; if ({a_pc_write, a_ifid_write, a_idex_bubble, a_ifid_flush, a_muldiv_busy} !== 5'b11000)
            $display("FAIL reset_a_outputs: got %b expected 11000", {a_pc_write, a_ifid_write, a_idex_bubble, a_ifid_flush, a_muldiv_busy});
        else n_pass++;
        n_total++; if ({b_pc_write, b_ifid_write, b_idex_bubble, b_ifid_flush, b_muldiv_busy} !== 5'b11000)
            $display("FAIL reset_b_outputs: got %b expected 11000", {b_pc_write, b_ifid_write, b_idex_bubble, b_ifid_flush, b_muldiv_busy});
        else n_pass++;
        n_total++; if (a_stall_cycles !== 32'd0 || b_stall_cycles !== 4'd0)
            $display("FAIL reset_stall_cycles: got a=%0d b=%0d expected 0 0", a_stall_cycles, b_stall_cycles);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_hit_rs5();
        #1;
        n_total++; if (a_pc_write !== 1'b0 || a_idex_bubble !== 1'b1 || a_ifid_write !== 1'b0)
            $display("FAIL load_a_stall: got pc=%b bub=%b ifid=%b expected 0 1 0", a_pc_write, a_idex_bubble, a_ifid_write);
        else n_pass++;
        @(negedge clk);
        clear_inputs();
        #1;
        n_total++; if (a_pc_write !== 1'b1 || a_idex_bubble !== 1'b0)
            $display("FAIL load_a_release: got pc=%b bub=%b expected 1 0", a_pc_write, a_idex_bubble);
        else n_pass++;
        n_total++; if (b_pc_write !== 1'b0 || b_idex_bubble !== 1'b1)
            $display("FAIL load_b_wait1: got pc=%b bub=%b expected 0 1", b_pc_write, b_idex_bubble);
        else n_pass++;
        @(negedge clk); #1;
        n_total++; if (b_pc_write !== 1'b0)
            $display("FAIL load_b_wait2: got pc=%b expected 0", b_pc_write);
        else n_pass++;
        @(negedge clk); #1;
        n_total++; if (b_pc_write !== 1'b1 || b_idex_bubble !== 1'b0)
            $display("FAIL load_b_run: got pc=%b bub=%b expected 1 0", b_pc_write, b_idex_bubble);
        else n_pass++;
        n_total++; if (a_stall_cycles !== 32'd1 || b_stall_cycles !== 4'd3)
            $display("FAIL load_counts: got a=%0d b=%0d expected 1 3", a_stall_cycles, b_stall_cycles);
        else n_pass++;
        // rt matches but the instruction does not read rt
        exe_mem_read = 1; exe_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 0;
        #1;
        n_total++; if (a_pc_write !== 1'b1 || b_pc_write !== 1'b1)
            $display("FAIL load_rt_unused: got a=%b b=%b expected 1 1", a_pc_write, b_pc_write);
        else n_pass++;
        clear_inputs();
        exe_mem_read = 1; exe_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
        #1;
        n_total++; if (a_pc_write !== 1'b1 || b_pc_write !== 1'b1)
            $display("FAIL load_reg0: got a=%b b=%b expected 1 1", a_pc_write, b_pc_write);
        else n_pass++;
        clear_inputs();
        exe_mem_read = 1; exe_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1;
        #1;
        n_total++; if (a_pc_write !== 1'b0 || b_pc_write !== 1'b0)
            $display("FAIL load_rt_used: got a=%b b=%b expected 0 0", a_pc_write, b_pc_write);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_muldiv();
        do_reset();
        exe_muldiv_start = 1;
        #1;
        n_total++; if (a_muldiv_busy !== 1'b0)
            $display("FAIL md_busy_start: got %b expected 0", a_muldiv_busy);
        else n_pass++;
        @(negedge clk);
        exe_muldiv_start = 0; id_uses_hilo = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (a_muldiv_busy !== 1'b1 || a_pc_write !== 1'b0 || a_idex_bubble !== 1'b1)
                $display("FAIL md_stall_%0d: got busy=%b pc=%b bub=%b expected 1 0 1", i, a_muldiv_busy, a_pc_write, a_idex_bubble);
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_total++; if (a_muldiv_busy !== 1'b0 || a_pc_write !== 1'b1)
            $display("FAIL md_done: got busy=%b pc=%b expected 0 1", a_muldiv_busy, a_pc_write);
        else n_pass++;
        n_total++; if (a_stall_cycles !== 32'd4 || b_stall_cycles !== 4'd4)
            $display("FAIL md_counts: got a=%0d b=%0d expected 4 4", a_stall_cycles, b_stall_cycles);
        else n_pass++;
        id_uses_hilo = 0; exe_muldiv_start = 1;
        @(negedge clk);
        exe_muldiv_start = 0;
        #1;
        n_total++; if (a_muldiv_busy !== 1'b1 || a_pc_write !== 1'b1)
            $display("FAIL md_addu_nostall: got busy=%b pc=%b expected 1 1", a_muldiv_busy, a_pc_write);
        else n_pass++;
        // reload two cycles into the run: busy must last four more cycles
        repeat (2) @(negedge clk);
        exe_muldiv_start = 1;
        @(negedge clk);
        exe_muldiv_start = 0;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (a_muldiv_busy !== 1'b1)
            $display("FAIL md_reload_busy: got %b expected 1", a_muldiv_busy);
        else n_pass++;
        @(negedge clk); #1;
        n_total++; if (a_muldiv_busy !== 1'b0)
            $display("FAIL md_reload_done: got %b expected 0", a_muldiv_busy);
        else n_pass++;
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_load_hit_rs5();
        @(negedge clk);
        clear_inputs();
        exe_branch_taken = 1;
        #1;
        n_total++; if ({b_ifid_flush, b_pc_write, b_ifid_write, b_idex_bubble} !== 4'b1111)
            $display("FAIL br_b_outputs: got %b expected 1111", {b_ifid_flush, b_pc_write, b_ifid_write, b_idex_bubble});
        else n_pass++;
        n_total++; if ({a_ifid_flush, a_pc_write, a_ifid_write, a_idex_bubble} !== 4'b1111)
            $display("FAIL br_a_outputs: got %b expected 1111", {a_ifid_flush, a_pc_write, a_ifid_write, a_idex_bubble});
        else n_pass++;
        @(negedge clk);
        exe_branch_taken = 0;
        #1;
        n_total++; if (b_pc_write !== 1'b1 || b_idex_bubble !== 1'b0 || b_ifid_flush !== 1'b0)
            $display("FAIL br_b_back_to_run: got pc=%b bub=%b fl=%b expected 1 0 0", b_pc_write, b_idex_bubble, b_ifid_flush);
        else n_pass++;
        @(negedge clk); #1;
        n_total++; if (b_stall_cycles !== 4'd1)
            $display("FAIL br_b_count: got %0d expected 1", b_stall_cycles);
        else n_pass++;
    endtask

    task automatic test_jump_vs_load();
        do_reset();
        set_load_hit_rs5();
        id_jump = 1;
        #1;
        n_total++; if (a_ifid_flush !== 1'b0 || a_pc_write !== 1'b0)
            $display("FAIL jmp_suppressed: got fl=%b pc=%b expected 0 0", a_ifid_flush, a_pc_write);
        else n_pass++;
        @(negedge clk);
        exe_mem_read = 0;
        #1;
        n_total++; if (a_ifid_flush !== 1'b1 || a_pc_write !== 1'b1 || a_idex_bubble !== 1'b0)
            $display("FAIL jmp_flush_next: got fl=%b pc=%b bub=%b expected 1 1 0", a_ifid_flush, a_pc_write, a_idex_bubble);
        else n_pass++;
        n_total++; if (b_ifid_flush !== 1'b0 || b_pc_write !== 1'b0)
            $display("FAIL jmp_b_in_wait: got fl=%b pc=%b expected 0 0", b_ifid_flush, b_pc_write);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_load_hit_rs5();
        exe_muldiv_start = 1;
        @(negedge clk);
        clear_inputs();
        id_uses_hilo = 1;
        #1;
        n_total++; if (b_pc_write !== 1'b0 || b_muldiv_busy !== 1'b1)
            $display("FAIL rmid_pre: got pc=%b busy=%b expected 0 1", b_pc_write, b_muldiv_busy);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if ({b_pc_write, b_ifid_write, b_idex_bubble, b_ifid_flush, b_muldiv_busy} !== 5'b11000)
            $display("FAIL rmid_b_outputs: got %b expected 11000", {b_pc_write, b_ifid_write, b_idex_bubble, b_ifid_flush, b_muldiv_busy});
        else n_pass++;
        n_total++; if (b_stall_cycles !== 4'd0 || a_stall_cycles !== 32'd0 || a_muldiv_busy !== 1'b0)
            $display("FAIL rmid_state: got b=%0d a=%0d abusy=%b expected 0 0 0", b_stall_cycles, a_stall_cycles, a_muldiv_busy);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if (b_pc_write !== 1'b1 || b_idex_bubble !== 1'b0 || b_muldiv_busy !== 1'b0)
            $display("FAIL rmid_release: got pc=%b bub=%b busy=%b expected 1 0 0", b_pc_write, b_idex_bubble, b_muldiv_busy);
        else n_pass++;
        @(negedge clk); #1;
        n_total++; if (b_stall_cycles !== 4'd0 || b_pc_write !== 1'b1)
            $display("FAIL rmid_after: got cnt=%0d pc=%b expected 0 1", b_stall_cycles, b_pc_write);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_hit_rs5();
        repeat (20) @(negedge clk);
        #1;
        n_total++; if (a_stall_cycles !== 32'd20)
            $display("FAIL sat_a_count: got %0d expected 20", a_stall_cycles);
        else n_pass++;
        n_total++; if (b_stall_cycles !== 4'd15)
            $display("FAIL sat_b_hold: got %0d expected 15", b_stall_cycles);
        else n_pass++;
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_branch_flush();
        test_jump_vs_load();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
